lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
- Drives the 4-bit LCD nibble-transfer engine by generating its sendCommand, command, command_rs and commandDelay inputs and consuming its commandDone.
- After reset, runs the HD44780 power-on wait and 4-bit initialisation sequence on its own.
- Then accepts byte writes (command or data) from a client over a valid/ready handshake. Each byte is split into a high nibble and a low nibble, each issued with the correct post-nibble delay.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz; documentation only, the cycle counts below assume it.
- POWERON_CYCLES, 750000, wait after reset before the first nibble (15 ms).
- INIT1_DELAY, 205000, delay after the first 0x3 nibble (4.1 ms).
- INIT2_DELAY, 5000, delay after the second 0x3 nibble (100 us).
- CMD_DELAY, 2000, delay after the low nibble of a normal command or data byte (40 us).
- CLEAR_DELAY, 82000, delay after the low nibble of clear (0x01) or home (0x02/0x03) (1.64 ms).
- NIBBLE_DELAY, 50, delay after any high nibble (1 us).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- wr_valid  in  1  client byte request.
- wr_data  in  8  byte to send.
- wr_rs  in  1  0 = instruction, 1 = data.
- wr_ready  out  1  high when a byte can be accepted.
- init_done  out  1  high once initialisation completes; stays high until reset.
- sendCommand  out  1  one-cycle start pulse to the transfer engine.
- command  out  4  nibble to transfer.
- command_rs  out  1  RS for the nibble.
- commandDelay  out  21  post-nibble busy cycles.
- commandDone  in  1  one-cycle completion pulse from the transfer engine.

Behaviour:
- Outputs and registers:
  - All outputs are registered.
  - In reset: wr_ready=0, init_done=0, sendCommand=0, command=0, command_rs=0, commandDelay=0, state=PWR_WAIT, internal counter=0, step index=0.
- States: PWR_WAIT, ISSUE, WAIT_DONE, GAP, IDLE.
- Step source: the step source is either the init ROM (step index 0..13) or the latched client byte (two steps: high nibble, then low nibble).
- Init ROM (nibble/delay), all with rs=0:
  - 0x3/INIT1_DELAY
  - 0x3/INIT2_DELAY
  - 0x3/CMD_DELAY
  - 0x2/CMD_DELAY
  - Then bytes 0x28, 0x08, 0x01, 0x06, 0x0C. Each byte is its high nibble with NIBBLE_DELAY, then its low nibble with CMD_DELAY; byte 0x01's low nibble uses CLEAR_DELAY.
- PWR_WAIT: counter increments each cycle. When it reaches POWERON_CYCLES-1, go to ISSUE with step 0.
- ISSUE:
  - For exactly one cycle, drive sendCommand=1 with command, command_rs and commandDelay of the current step.
  - These three values hold stable from the ISSUE cycle until the next ISSUE.
  - Next state is WAIT_DONE.
- WAIT_DONE: wait for commandDone=1.
  - If more steps remain, go to GAP.
  - After step 13 of init, set init_done=1 and go to IDLE.
  - After a client low nibble, go to IDLE.
- GAP: exactly one cycle, then ISSUE with the next step. This guarantees sendCommand rises no earlier than 2 edges after commandDone is sampled, so the engine is back in idle.
- IDLE: wr_ready=1.
  - On wr_valid && wr_ready (the handshake edge), latch wr_data/wr_rs, drop wr_ready the same edge, and go to ISSUE with the high nibble.
  - wr_ready is 0 in every other state, including all of init.
- Client byte delay selection:
  - High nibble = wr_data[7:4] with NIBBLE_DELAY.
  - Low nibble = wr_data[3:0] with CLEAR_DELAY if wr_rs=0 and wr_data is in {0x01, 0x02, 0x03}; otherwise CMD_DELAY.
  - command_rs = latched wr_rs for both nibbles.
- Latency: from the handshake edge, sendCommand is high in the next cycle (ISSUE).
- commandDone received outside WAIT_DONE is ignored.
- wr_data changing after handshake has no effect.
- wr_valid held during init is neither accepted nor lost; it is accepted on the first IDLE cycle.
- Reset mid-operation: immediate return to reset values and re-run of the full power-on wait and init sequence.
  - The transfer engine has no reset. POWERON_CYCLES must exceed the maximum outstanding engine busy time (CLEAR_DELAY plus overhead), which holds with the defaults.
- Widths: delays are zero-extended to 21 bits; the counter is 20 bits minimum.

Test Plan:
- Power-on timing: release RST_N -> first sendCommand pulse exactly POWERON_CYCLES+1 edges later, with command=0x3, commandDelay=205000.
- Init sequence (engine model returns commandDone after commandDelay) -> 14 pulses with nibbles 3,3,3,2,2,8,0,8,0,1,0,6,0,C and the listed delays. init_done rises after the 14th commandDone, and wr_ready rises the same cycle.
- Write 0x41 with wr_rs=1 -> pulse command=0x4/rs=1/delay=50, then command=0x1/rs=1/delay=2000. Each pulse is 2 edges after the previous commandDone. wr_ready returns high after the second commandDone.
- Write 0x01 with wr_rs=0 -> low nibble delay=82000. Write 0x01 with wr_rs=1 -> low nibble delay=2000.
- wr_valid held from reset -> not accepted until init_done=1, then accepted exactly once, with exactly 2 pulses.
- Assert RST_N low during WAIT_DONE of a client byte -> all outputs return to 0 asynchronously. After release, the full init sequence repeats, and a stray commandDone during PWR_WAIT is ignored.

Source files
------------

// File: rtl/lcd_sequencer.sv
// +----------------------------------------------------------------------------+
// | lcd_sequencer: HD44780 4-bit init and byte writer for a nibble engine      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module lcd_sequencer #(
  parameter int CLK_FREQ       = 50000000,
  parameter int POWERON_CYCLES = 750000,
  parameter int INIT1_DELAY    = 205000,
  parameter int INIT2_DELAY    = 5000,
  parameter int CMD_DELAY      = 2000,
  parameter int CLEAR_DELAY    = 82000,
  parameter int NIBBLE_DELAY   = 50
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        wr_rs,
  output logic        wr_ready,
  output logic        init_done,
  output logic        sendCommand,
  output logic [3:0]  command,
  output logic        command_rs,
  output logic [20:0] commandDelay,
  input  logic        commandDone
);

  // CLK_FREQ only documents the timing; it gates nothing beyond this width pick.
  localparam int c_cnt_w = ($clog2(POWERON_CYCLES + 1) > 20 && CLK_FREQ > 0) ?
                           $clog2(POWERON_CYCLES + 1) : 20;

  localparam logic [20:0] c_init1 = 21'(INIT1_DELAY);
  localparam logic [20:0] c_init2 = 21'(INIT2_DELAY);
  localparam logic [20:0] c_cmd   = 21'(CMD_DELAY);
  localparam logic [20:0] c_clear = 21'(CLEAR_DELAY);
  localparam logic [20:0] c_nib   = 21'(NIBBLE_DELAY);

  typedef enum logic [2:0] {
    PWR_WAIT  = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    IDLE      = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_step;
  logic                 r_client;
  logic [7:0]           r_byte;
  logic                 r_rs;

  logic [3:0]           w_nibble;
  logic [20:0]          w_delay;
  logic                 w_rs;
  logic                 w_slow_cmd;

  // Clear and home need the long settle time; only as instructions.
  assign w_slow_cmd = !r_rs && (r_byte == 8'h01 || r_byte == 8'h02 || r_byte == 8'h03);

  always_comb begin
    w_nibble = 4'h0;
    w_delay  = c_cmd;
    w_rs     = 1'b0;
    if (r_client) begin
      w_rs = r_rs;
      if (r_step == 4'd0) begin
        w_nibble = r_byte[7:4];
        w_delay  = c_nib;
      end else begin
        w_nibble = r_byte[3:0];
        w_delay  = w_slow_cmd ? c_clear : c_cmd;
      end
    end else begin
      case (r_step)
        4'd0:    begin w_nibble = 4'h3; w_delay = c_init1; end
        4'd1:    begin w_nibble = 4'h3; w_delay = c_init2; end
        4'd2:    begin w_nibble = 4'h3; w_delay = c_cmd;   end
        4'd3:    begin w_nibble = 4'h2; w_delay = c_cmd;   end
        4'd4:    begin w_nibble = 4'h2; w_delay = c_nib;   end
        4'd5:    begin w_nibble = 4'h8; w_delay = c_cmd;   end
        4'd6:    begin w_nibble = 4'h0; w_delay = c_nib;   end
        4'd7:    begin w_nibble = 4'h8; w_delay = c_cmd;   end
        4'd8:    begin w_nibble = 4'h0; w_delay = c_nib;   end
        4'd9:    begin w_nibble = 4'h1; w_delay = c_clear; end
        4'd10:   begin w_nibble = 4'h0; w_delay = c_nib;   end
        4'd11:   begin w_nibble = 4'h6; w_delay = c_cmd;   end
        4'd12:   begin w_nibble = 4'h0; w_delay = c_nib;   end
        4'd13:   begin w_nibble = 4'hC; w_delay = c_cmd;   end
        default: begin w_nibble = 4'h0; w_delay = c_cmd;   end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= PWR_WAIT;
      r_cnt        <= '0;
      r_step       <= 4'd0;
      r_client     <= 1'b0;
      r_byte       <= 8'h00;
      r_rs         <= 1'b0;
      wr_ready     <= 1'b0;
      init_done    <= 1'b0;
      sendCommand  <= 1'b0;
      command      <= 4'h0;
      command_rs   <= 1'b0;
      commandDelay <= 21'd0;
    end else begin
      sendCommand <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          if (r_cnt == c_cnt_w'(POWERON_CYCLES - 1)) begin
            r_state  <= ISSUE;
            r_step   <= 4'd0;
            r_client <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ISSUE: begin
          sendCommand  <= 1'b1;
          command      <= w_nibble;
          command_rs   <= w_rs;
          commandDelay <= w_delay;
          r_state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (commandDone) begin
            if (r_client ? (r_step == 4'd1) : (r_step == 4'd13)) begin
              r_state   <= IDLE;
              wr_ready  <= 1'b1;
              init_done <= 1'b1;
            end else begin
              r_step  <= r_step + 4'd1;
              r_state <= GAP;
            end
          end
        end
        // One spare cycle so the engine has returned to idle before the next start.
        GAP: r_state <= ISSUE;
        IDLE: begin
          if (wr_valid && wr_ready) begin
            r_byte   <= wr_data;
            r_rs     <= wr_rs;
            r_client <= 1'b1;
            r_step   <= 4'd0;
            wr_ready <= 1'b0;
            r_state  <= ISSUE;
          end
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_lcd_sequencer: directed vectors against lcd_sequencer with engine model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lcd_sequencer;

  localparam int P   = 200;
  localparam int D1  = 60;
  localparam int D2  = 30;
  localparam int DC  = 20;
  localparam int DCL = 40;
  localparam int DN  = 5;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_rs = 1'b0;
  logic        commandDone;
  logic        wr_ready;
  logic        init_done;
  logic        sendCommand;
  logic [3:0]  command;
  logic        command_rs;
  logic [20:0] commandDelay;

  lcd_sequencer #(
    .CLK_FREQ      (50000000),
    .POWERON_CYCLES(P),
    .INIT1_DELAY   (D1),
    .INIT2_DELAY   (D2),
    .CMD_DELAY     (DC),
    .CLEAR_DELAY   (DCL),
    .NIBBLE_DELAY  (DN)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_rs       (wr_rs),
    .wr_ready    (wr_ready),
    .init_done   (init_done),
    .sendCommand (sendCommand),
    .command     (command),
    .command_rs  (command_rs),
    .commandDelay(commandDelay),
    .commandDone (commandDone)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  nib;
    logic        rs;
    logic [20:0] dly;
    int          rise;
    int          gap;
  } pulse_t;

  typedef struct {
    logic [3:0]  nib;
    logic [20:0] dly;
  } init_vec_t;

  typedef struct {
    logic [7:0]  data;
    logic        rs;
    logic [3:0]  hi;
    logic [3:0]  lo;
    logic [20:0] lo_dly;
  } wr_vec_t;

  pulse_t    pq[$];
  init_vec_t init_tbl[14];
  wr_vec_t   wr_tbl[8];
  int        cyc = 0;
  int        done_samp = 0;
  int        checks = 0;
  int        failures = 0;
  pulse_t    ep;
  int        edly;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Nibble engine model: busy for commandDelay cycles, then a one-cycle done.
  initial begin
    commandDone = 1'b0;
    forever begin
      @(negedge CLK);
      if (sendCommand === 1'b1) begin
        ep.nib  = command;
        ep.rs   = command_rs;
        ep.dly  = commandDelay;
        ep.rise = cyc;
        ep.gap  = cyc - done_samp;
        pq.push_back(ep);
        edly = int'(commandDelay);
        @(negedge CLK);
        check("send_pulse_width", 32'(sendCommand), 32'd0);
        repeat (edly) @(negedge CLK);
        commandDone = 1'b1;
        done_samp   = cyc + 1;
        @(negedge CLK);
        commandDone = 1'b0;
      end
    end
  end

  task automatic get_pulse(input string name, output pulse_t p);
    int n = 0;
    while (pq.size() == 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (pq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no sendCommand pulse within 3000 cycles", name);
      p = '{default: 0};
    end else begin
      p = pq.pop_front();
    end
  endtask

  // which = 0 waits for wr_ready, 1 waits for init_done
  task automatic wait_high(input bit which, input string name);
    int n = 0;
    while ((which ? init_done : wr_ready) !== 1'b1 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if ((which ? init_done : wr_ready) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s: signal still low after 3000 cycles", name);
    end
  endtask

  task automatic run_init(input int rel, output int dsamp);
    pulse_t p;
    for (int i = 0; i < 14; i++) begin
      get_pulse($sformatf("init%0d", i), p);
      check($sformatf("init%0d_nib", i), 32'(p.nib), 32'(init_tbl[i].nib));
      check($sformatf("init%0d_rs", i), 32'(p.rs), 32'd0);
      check($sformatf("init%0d_dly", i), 32'(p.dly), 32'(init_tbl[i].dly));
      if (i == 0) check("poweron_edge", 32'(p.rise), 32'(rel + P + 1));
      else        check($sformatf("init%0d_gap", i), 32'(p.gap), 32'd2);
    end
    check("init_done_early", 32'(init_done), 32'd0);
    check("ready_during_init", 32'(wr_ready), 32'd0);
    wait_high(1'b1, "init_done_rise");
    check("init_done_edge", 32'(cyc), 32'(done_samp));
    check("ready_with_init_done", 32'(wr_ready), 32'd1);
    dsamp = cyc;
  endtask

  task automatic write_byte(input wr_vec_t v, input int idx);
    pulse_t p;
    int     hs;
    wait_high(1'b0, $sformatf("wr%0d_ready", idx));
    wr_valid = 1'b1;
    wr_data  = v.data;
    wr_rs    = v.rs;
    @(negedge CLK);
    hs = cyc;
    check($sformatf("wr%0d_ready_drop", idx), 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    wr_data  = ~v.data;
    wr_rs    = ~v.rs;
    get_pulse($sformatf("wr%0d_hi", idx), p);
    check($sformatf("wr%0d_hi_edge", idx), 32'(p.rise), 32'(hs + 1));
    check($sformatf("wr%0d_hi_nib", idx), 32'(p.nib), 32'(v.hi));
    check($sformatf("wr%0d_hi_rs", idx), 32'(p.rs), 32'(v.rs));
    check($sformatf("wr%0d_hi_dly", idx), 32'(p.dly), 32'(DN));
    get_pulse($sformatf("wr%0d_lo", idx), p);
    check($sformatf("wr%0d_lo_gap", idx), 32'(p.gap), 32'd2);
    check($sformatf("wr%0d_lo_nib", idx), 32'(p.nib), 32'(v.lo));
    check($sformatf("wr%0d_lo_rs", idx), 32'(p.rs), 32'(v.rs));
    check($sformatf("wr%0d_lo_dly", idx), 32'(p.dly), 32'(v.lo_dly));
    wait_high(1'b0, $sformatf("wr%0d_ready_back", idx));
    check($sformatf("wr%0d_ready_edge", idx), 32'(cyc), 32'(done_samp));
  endtask

  initial begin
    pulse_t p;
    int     rel;
    int     dsamp;

    init_tbl[0]  = '{4'h3, 21'(D1)};
    init_tbl[1]  = '{4'h3, 21'(D2)};
    init_tbl[2]  = '{4'h3, 21'(DC)};
    init_tbl[3]  = '{4'h2, 21'(DC)};
    init_tbl[4]  = '{4'h2, 21'(DN)};
    init_tbl[5]  = '{4'h8, 21'(DC)};
    init_tbl[6]  = '{4'h0, 21'(DN)};
    init_tbl[7]  = '{4'h8, 21'(DC)};
    init_tbl[8]  = '{4'h0, 21'(DN)};
    init_tbl[9]  = '{4'h1, 21'(DCL)};
    init_tbl[10] = '{4'h0, 21'(DN)};
    init_tbl[11] = '{4'h6, 21'(DC)};
    init_tbl[12] = '{4'h0, 21'(DN)};
    init_tbl[13] = '{4'hC, 21'(DC)};

    wr_tbl[0] = '{8'h41, 1'b1, 4'h4, 4'h1, 21'(DC)};
    wr_tbl[1] = '{8'h01, 1'b0, 4'h0, 4'h1, 21'(DCL)};
    wr_tbl[2] = '{8'h01, 1'b1, 4'h0, 4'h1, 21'(DC)};
    wr_tbl[3] = '{8'h02, 1'b0, 4'h0, 4'h2, 21'(DCL)};
    wr_tbl[4] = '{8'h03, 1'b0, 4'h0, 4'h3, 21'(DCL)};
    wr_tbl[5] = '{8'h04, 1'b0, 4'h0, 4'h4, 21'(DC)};
    wr_tbl[6] = '{8'hA5, 1'b1, 4'hA, 4'h5, 21'(DC)};
    wr_tbl[7] = '{8'h11, 1'b0, 4'h1, 4'h1, 21'(DC)};

    // Reset state, with a client request already pending
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    wr_rs    = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_send", 32'(sendCommand), 32'd0);
    check("rst_command", 32'(command), 32'd0);
    check("rst_command_rs", 32'(command_rs), 32'd0);
    check("rst_delay", 32'(commandDelay), 32'd0);

    RST_N = 1'b1;
    rel = cyc;
    run_init(rel, dsamp);

    // Pending request accepted on the first IDLE cycle, exactly once
    @(negedge CLK);
    check("held_accepted", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    get_pulse("held_hi", p);
    check("held_hi_edge", 32'(p.rise), 32'(dsamp + 2));
    check("held_hi_nib", 32'(p.nib), 32'h5);
    check("held_hi_rs", 32'(p.rs), 32'd1);
    check("held_hi_dly", 32'(p.dly), 32'(DN));
    get_pulse("held_lo", p);
    check("held_lo_nib", 32'(p.nib), 32'hA);
    check("held_lo_dly", 32'(p.dly), 32'(DC));
    wait_high(1'b0, "held_ready_back");
    repeat (60) @(negedge CLK);
    check("held_single_accept", 32'(pq.size()), 32'd0);

    for (int i = 0; i < 8; i++) write_byte(wr_tbl[i], i);

    // Reset while the low nibble of a clear is outstanding
    wait_high(1'b0, "rst_mid_ready");
    wr_valid = 1'b1;
    wr_data  = 8'h01;
    wr_rs    = 1'b0;
    @(negedge CLK);
    wr_valid = 1'b0;
    get_pulse("mid_hi", p);
    get_pulse("mid_lo", p);
    check("mid_lo_dly", 32'(p.dly), 32'(DCL));
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("async_send", 32'(sendCommand), 32'd0);
    check("async_command", 32'(command), 32'd0);
    check("async_delay", 32'(commandDelay), 32'd0);
    check("async_init_done", 32'(init_done), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    rel = cyc;
    repeat (P / 2) @(negedge CLK);
    check("stray_done_seen", 32'(done_samp > rel), 32'd1);
    check("no_pulse_in_pwr_wait", 32'(pq.size()), 32'd0);
    run_init(rel, dsamp);
    write_byte(wr_tbl[0], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
